// File: rtl/alu_seq.sv
// alu_seq: execute-stage ALU with a valid/ready handshake on both sides.
// Single-cycle ops finish one cycle after acceptance. MUL/MULH/DIV/REM use
// an iterative shift-add / restoring-subtract engine on operand magnitudes.
// The engine is followed by a one-cycle sign fix-up.
// Optional feature macro ALU_SEQ_DIV_EN:
//   defined   - divider datapath present, DIV/REM run on the iterative engine.
//   undefined - no divider; DIV/REM complete in one cycle with result 0, err=1.
module alu_seq #(
   parameter int SIZE = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      funct,
   input  logic [SIZE-1:0] a,
   input  logic [SIZE-1:0] b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [SIZE-1:0] result,
   output logic            overflow,
   output logic            negative,
   output logic            zero,
   output logic            equal,
   output logic            less,
   output logic            err
);

   localparam int SHW = $clog2(SIZE);

   localparam logic [3:0] F_SUM  = 4'd0;
   localparam logic [3:0] F_SUB  = 4'd1;
   localparam logic [3:0] F_SLL  = 4'd2;
   localparam logic [3:0] F_SRL  = 4'd3;
   localparam logic [3:0] F_SLA  = 4'd4;
   localparam logic [3:0] F_SRA  = 4'd5;
   localparam logic [3:0] F_LOAD = 4'd6;
   localparam logic [3:0] F_AND  = 4'd7;
   localparam logic [3:0] F_XOR  = 4'd8;
   localparam logic [3:0] F_NOT  = 4'd9;
   localparam logic [3:0] F_LESS = 4'd10;
   localparam logic [3:0] F_MUL  = 4'd11;
   localparam logic [3:0] F_MULH = 4'd12;
   localparam logic [3:0] F_DIV  = 4'd13;
   localparam logic [3:0] F_REM  = 4'd14;
   localparam logic [3:0] F_RSVD = 4'd15;

   typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} stateType;

   stateType        state;
   stateType        stateNext;
   logic            accept;
   logic            longOp;

   logic [3:0]      functReg;
   logic [SIZE-1:0] opA;
   logic [SIZE-1:0] opB;
   logic            negA;
   logic            negB;
   logic [SIZE-1:0] magB;
   logic [SIZE-1:0] hiReg;
   logic [SIZE-1:0] loReg;
   logic [SHW-1:0]  count;

   logic [SIZE-1:0] absA;
   logic [SIZE-1:0] absB;
   logic [SIZE-1:0] sumAB;
   logic [SIZE-1:0] diffAB;
   logic [SHW-1:0]  shamt;
   logic [SIZE-1:0] singleRes;
   logic            singleOvf;
   logic            singleErr;

   logic [SIZE:0]     mulSum;
   logic [2*SIZE-1:0] prodMag;
   logic [2*SIZE-1:0] prodSigned;
   logic [SIZE-1:0]   fixRes;
   logic              fixOvf;

`ifdef ALU_SEQ_DIV_EN
   localparam logic [SIZE-1:0] MIN_VAL = {1'b1, {(SIZE-1){1'b0}}};

   logic [SIZE:0]   divShift;
   logic            divBorrow;
   logic [SIZE-1:0] divDiff;
   logic [SIZE-1:0] quotSigned;
   logic [SIZE-1:0] remSigned;
`endif

   // Decide whether the incoming funct needs the iterative engine
   always_comb begin
      longOp = (funct == F_MUL) || (funct == F_MULH);
`ifdef ALU_SEQ_DIV_EN
      longOp = longOp || (funct == F_DIV) || (funct == F_REM);
`endif
   end

   // State register; reset drops any operation in flight back to IDLE
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // Handshake decode and next state: DONE can re-accept when the result is consumed
   always_comb begin
      in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
      out_valid = (state == DONE);
      accept    = in_valid && in_ready;
      stateNext = state;
      case (state)
         IDLE, DONE: begin
            if (accept) begin
               stateNext = longOp ? ITER : DONE;
            end else if (in_ready) begin
               stateNext = IDLE;
            end
         end
         ITER: begin
            if (count == '0) begin
               stateNext = FIX;
            end
         end
         FIX: begin
            stateNext = DONE;
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   // Single-cycle operations evaluated straight from the live operands
   always_comb begin
      absA      = a[SIZE-1] ? -a : a;
      absB      = b[SIZE-1] ? -b : b;
      sumAB     = a + b;
      diffAB    = a - b;
      shamt     = b[SHW-1:0];
      singleRes = '0;
      singleOvf = 1'b0;
      singleErr = 1'b0;
      case (funct)
         F_SUM: begin
            singleRes = sumAB;
            singleOvf = (a[SIZE-1] == b[SIZE-1]) && (sumAB[SIZE-1] != a[SIZE-1]);
         end
         F_SUB: begin
            singleRes = diffAB;
            singleOvf = (a[SIZE-1] != b[SIZE-1]) && (diffAB[SIZE-1] != a[SIZE-1]);
         end
         F_SLL, F_SLA: singleRes = a << shamt;
         F_SRL:        singleRes = a >> shamt;
         F_SRA:        singleRes = $signed(a) >>> shamt;
         F_LOAD:       singleRes = a;
         F_AND:        singleRes = a & b;
         F_XOR:        singleRes = a ^ b;
         F_NOT:        singleRes = ~a;
         F_LESS:       singleRes = {{(SIZE-1){1'b0}}, ($signed(a) < $signed(b))};
`ifndef ALU_SEQ_DIV_EN
         F_DIV, F_REM: singleErr = 1'b1;
`endif
         F_RSVD:       singleErr = 1'b1;
         default:      singleRes = '0;
      endcase
   end

   // One iteration step of the multiply (shift-add) and divide (restoring) engines
   always_comb begin
      mulSum = {1'b0, hiReg} + (loReg[0] ? {1'b0, magB} : '0);
`ifdef ALU_SEQ_DIV_EN
      divShift  = {hiReg, loReg[SIZE-1]};
      divBorrow = divShift < {1'b0, magB};
      divDiff   = divShift[SIZE-1:0] - magB;
`endif
   end

   // Sign fix-up of the magnitude result, plus division corner cases
   always_comb begin
      prodMag    = {hiReg, loReg};
      prodSigned = (negA ^ negB) ? -prodMag : prodMag;
      fixRes     = prodSigned[SIZE-1:0];
      fixOvf     = prodSigned[2*SIZE-1:SIZE] != {SIZE{prodSigned[SIZE-1]}};
      if (functReg == F_MULH) begin
         fixRes = prodSigned[2*SIZE-1:SIZE];
         fixOvf = 1'b0;
      end
`ifdef ALU_SEQ_DIV_EN
      quotSigned = (negA ^ negB) ? -loReg : loReg;
      remSigned  = negA ? -hiReg : hiReg;
      if (functReg == F_DIV) begin
         fixOvf = 1'b0;
         if (opB == '0) begin
            fixRes = '1;
         end else if ((opA == MIN_VAL) && (opB == '1)) begin
            fixRes = MIN_VAL;
            fixOvf = 1'b1;
         end else begin
            fixRes = quotSigned;
         end
      end else if (functReg == F_REM) begin
         fixOvf = 1'b0;
         if (opB == '0) begin
            fixRes = opA;
         end else if ((opA == MIN_VAL) && (opB == '1)) begin
            fixRes = '0;
         end else begin
            fixRes = remSigned;
         end
      end
`endif
   end

   // Operand latching, iteration registers and registered result/flags
   always_ff @(posedge clk) begin
      if (rst) begin
         functReg <= '0;
         opA      <= '0;
         opB      <= '0;
         negA     <= 1'b0;
         negB     <= 1'b0;
         magB     <= '0;
         hiReg    <= '0;
         loReg    <= '0;
         count    <= '0;
         result   <= '0;
         overflow <= 1'b0;
         negative <= 1'b0;
         zero     <= 1'b0;
         equal    <= 1'b0;
         less     <= 1'b0;
         err      <= 1'b0;
      end else if (accept) begin
         functReg <= funct;
         opA      <= a;
         opB      <= b;
         negA     <= a[SIZE-1];
         negB     <= b[SIZE-1];
         magB     <= absB;
         hiReg    <= '0;
         loReg    <= absA;
         count    <= SHW'(SIZE - 1);
         if (!longOp) begin
            result   <= singleRes;
            overflow <= singleOvf;
            negative <= singleRes[SIZE-1];
            zero     <= (singleRes == '0);
            equal    <= (a == b);
            less     <= ($signed(a) < $signed(b));
            err      <= singleErr;
         end
      end else if (state == ITER) begin
         count <= count - 1'b1;
`ifdef ALU_SEQ_DIV_EN
         if ((functReg == F_DIV) || (functReg == F_REM)) begin
            hiReg <= divBorrow ? divShift[SIZE-1:0] : divDiff;
            loReg <= {loReg[SIZE-2:0], !divBorrow};
         end else
`endif
         begin
            hiReg <= mulSum[SIZE:1];
            loReg <= {mulSum[0], loReg[SIZE-1:1]};
         end
      end else if (state == FIX) begin
         result   <= fixRes;
         overflow <= fixOvf;
         negative <= fixRes[SIZE-1];
         zero     <= (fixRes == '0);
         equal    <= (opA == opB);
         less     <= ($signed(opA) < $signed(opB));
         err      <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and randomized checks of alu_seq at SIZE=8 against an
// arithmetic reference model. Follows the ALU_SEQ_DIV_EN macro of the build.
module tb_alu_seq;

   localparam int W = 8;

   logic         clk;
   logic         rst;
   logic         inValid;
   logic         inReady;
   logic [3:0]   functIn;
   logic [W-1:0] aIn;
   logic [W-1:0] bIn;
   logic         outValid;
   logic         outReady;
   logic [W-1:0] resultOut;
   logic         overflowOut;
   logic         negativeOut;
   logic         zeroOut;
   logic         equalOut;
   logic         lessOut;
   logic         errOut;

   int checks = 0;
   int errors = 0;
   int cycle  = 0;
   int acceptCycle = 0;

   alu_seq #(.SIZE(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (inValid),
      .in_ready  (inReady),
      .funct     (functIn),
      .a         (aIn),
      .b         (bIn),
      .out_valid (outValid),
      .out_ready (outReady),
      .result    (resultOut),
      .overflow  (overflowOut),
      .negative  (negativeOut),
      .zero      (zeroOut),
      .equal     (equalOut),
      .less      (lessOut),
      .err       (errOut)
   );

   // Free-running 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Count rising edges so latency can be measured in cycles
   always @(posedge clk) cycle <= cycle + 1;

   // Hard stop if the bench ever stalls
   initial begin
      #500000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference model: plain signed integer arithmetic on 8-bit operands
   function automatic void refModel(input logic [3:0] f, input logic [W-1:0] ra, input logic [W-1:0] rb,
                                    output logic [W-1:0] res, output logic ovf, output logic er,
                                    output int lat);
      int sa;
      int sb;
      int full;
      int sh;
      sa   = int'($signed(ra));
      sb   = int'($signed(rb));
      sh   = int'(rb) % W;
      full = 0;
      res  = '0;
      ovf  = 1'b0;
      er   = 1'b0;
      lat  = 1;
      case (f)
         4'd0: begin full = sa + sb; res = full[7:0]; ovf = (full > 127) || (full < -128); end
         4'd1: begin full = sa - sb; res = full[7:0]; ovf = (full > 127) || (full < -128); end
         4'd2, 4'd4: begin full = int'(ra) << sh; res = full[7:0]; end
         4'd3: begin full = int'(ra) >> sh; res = full[7:0]; end
         4'd5: begin full = sa >>> sh; res = full[7:0]; end
         4'd6: res = ra;
         4'd7: res = ra & rb;
         4'd8: res = ra ^ rb;
         4'd9: res = ~ra;
         4'd10: res = (sa < sb) ? 8'd1 : 8'd0;
         4'd11: begin full = sa * sb; res = full[7:0]; ovf = (full > 127) || (full < -128); lat = W + 2; end
         4'd12: begin full = sa * sb; res = full[15:8]; lat = W + 2; end
`ifdef ALU_SEQ_DIV_EN
         4'd13: begin
            lat = W + 2;
            if (sb == 0) res = 8'hFF;
            else if (sa == -128 && sb == -1) begin res = 8'h80; ovf = 1'b1; end
            else begin full = sa / sb; res = full[7:0]; end
         end
         4'd14: begin
            lat = W + 2;
            if (sb == 0) res = ra;
            else if (sa == -128 && sb == -1) res = 8'h00;
            else begin full = sa % sb; res = full[7:0]; end
         end
`else
         4'd13, 4'd14: er = 1'b1;
`endif
         default: er = 1'b1;
      endcase
   endfunction

   // Present one request and hold it until the DUT accepts it
   task automatic applyStimulus(input logic [3:0] f, input logic [W-1:0] va, input logic [W-1:0] vb);
      int waited;
      waited  = 0;
      functIn = f;
      aIn     = va;
      bIn     = vb;
      inValid = 1'b1;
      while (inReady !== 1'b1 && waited < 40) begin
         @(negedge clk);
         waited++;
      end
      checkVal("accept wait", {63'd0, inReady}, 64'd1);
      acceptCycle = cycle;
      @(negedge clk);
      inValid = 1'b0;
   endtask

   // Wait for the response and compare everything against the model
   task automatic checkOutput(input logic [3:0] f, input logic [W-1:0] va, input logic [W-1:0] vb,
                              output logic [W-1:0] expRes);
      logic ovf;
      logic er;
      int   lat;
      int   waited;
      refModel(f, va, vb, expRes, ovf, er, lat);
      waited = 0;
      while (outValid !== 1'b1 && waited < 40) begin
         @(negedge clk);
         waited++;
      end
      checkVal($sformatf("f%0d out_valid", f), {63'd0, outValid}, 64'd1);
      checkVal($sformatf("f%0d latency", f), 64'(cycle - acceptCycle), 64'(lat));
      checkVal($sformatf("f%0d result a=%0h b=%0h", f, va, vb), {56'd0, resultOut}, {56'd0, expRes});
      checkVal($sformatf("f%0d overflow", f), {63'd0, overflowOut}, {63'd0, ovf});
      checkVal($sformatf("f%0d negative", f), {63'd0, negativeOut}, {63'd0, expRes[W-1]});
      checkVal($sformatf("f%0d zero", f), {63'd0, zeroOut}, {63'd0, (expRes == '0)});
      checkVal($sformatf("f%0d equal", f), {63'd0, equalOut}, {63'd0, (va == vb)});
      checkVal($sformatf("f%0d less", f), {63'd0, lessOut}, {63'd0, ($signed(va) < $signed(vb))});
      checkVal($sformatf("f%0d err", f), {63'd0, errOut}, {63'd0, er});
   endtask

   // Directed scenarios followed by a randomized sweep
   initial begin
      logic [W-1:0] expRes;
      logic [3:0]   rf;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      int           seen;

      rst      = 1'b1;
      inValid  = 1'b0;
      outReady = 1'b1;
      functIn  = '0;
      aIn      = '0;
      bIn      = '0;
      $display("[TB] start");

      repeat (3) @(negedge clk);
      checkVal("reset out_valid", {63'd0, outValid}, 64'd0);
      checkVal("reset result", {56'd0, resultOut}, 64'd0);
      checkVal("reset flags", {58'd0, overflowOut, negativeOut, zeroOut, equalOut, lessOut, errOut}, 64'd0);
      rst = 1'b0;
      @(negedge clk);
      checkVal("post-reset in_ready", {63'd0, inReady}, 64'd1);
      checkVal("post-reset out_valid", {63'd0, outValid}, 64'd0);

      applyStimulus(4'd0, 8'h7F, 8'h01);
      checkOutput(4'd0, 8'h7F, 8'h01, expRes);
      checkVal("SUM 7F+01 result", {56'd0, resultOut}, 64'h80);
      checkVal("SUM 7F+01 overflow", {63'd0, overflowOut}, 64'd1);
      @(negedge clk);

      functIn = 4'd1; aIn = 8'd5; bIn = 8'd5; inValid = 1'b1;
      checkVal("stream in_ready 0", {63'd0, inReady}, 64'd1);
      @(negedge clk);
      functIn = 4'd10; aIn = 8'hFD; bIn = 8'h02;
      checkVal("stream in_ready 1", {63'd0, inReady}, 64'd1);
      checkVal("stream SUB valid", {63'd0, outValid}, 64'd1);
      checkVal("stream SUB result", {56'd0, resultOut}, 64'd0);
      checkVal("stream SUB zero/equal", {62'd0, zeroOut, equalOut}, 64'd3);
      @(negedge clk);
      inValid = 1'b0;
      checkVal("stream in_ready 2", {63'd0, inReady}, 64'd1);
      checkVal("stream LESS valid", {63'd0, outValid}, 64'd1);
      checkVal("stream LESS result", {56'd0, resultOut}, 64'd1);
      checkVal("stream LESS less", {63'd0, lessOut}, 64'd1);
      @(negedge clk);

      applyStimulus(4'd11, 8'hF9, 8'h06);
      checkOutput(4'd11, 8'hF9, 8'h06, expRes);
      checkVal("MUL -7*6 result", {56'd0, resultOut}, 64'hD6);
      checkVal("MUL -7*6 latency", 64'(cycle - acceptCycle), 64'd10);
      applyStimulus(4'd12, 8'hF9, 8'h06);
      checkOutput(4'd12, 8'hF9, 8'h06, expRes);
      checkVal("MULH -7*6 result", {56'd0, resultOut}, 64'hFF);

`ifdef ALU_SEQ_DIV_EN
      applyStimulus(4'd13, 8'hF9, 8'h02);
      checkOutput(4'd13, 8'hF9, 8'h02, expRes);
      checkVal("DIV -7/2", {56'd0, resultOut}, 64'hFD);
      applyStimulus(4'd14, 8'hF9, 8'h02);
      checkOutput(4'd14, 8'hF9, 8'h02, expRes);
      checkVal("REM -7%2", {56'd0, resultOut}, 64'hFF);
      applyStimulus(4'd13, 8'h05, 8'h00);
      checkOutput(4'd13, 8'h05, 8'h00, expRes);
      checkVal("DIV 5/0", {56'd0, resultOut}, 64'hFF);
      applyStimulus(4'd13, 8'h80, 8'hFF);
      checkOutput(4'd13, 8'h80, 8'hFF, expRes);
      checkVal("DIV MIN/-1 result", {56'd0, resultOut}, 64'h80);
      checkVal("DIV MIN/-1 overflow", {63'd0, overflowOut}, 64'd1);
`else
      applyStimulus(4'd13, 8'h09, 8'h03);
      checkOutput(4'd13, 8'h09, 8'h03, expRes);
      checkVal("DIV disabled err", {63'd0, errOut}, 64'd1);
      checkVal("DIV disabled latency", 64'(cycle - acceptCycle), 64'd1);
`endif
      @(negedge clk);

      outReady = 1'b0;
      applyStimulus(4'd11, 8'h0D, 8'hF5);
      checkOutput(4'd11, 8'h0D, 8'hF5, expRes);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkVal($sformatf("hold %0d result", i), {56'd0, resultOut}, {56'd0, expRes});
         checkVal($sformatf("hold %0d valid/ready", i), {62'd0, outValid, inReady}, 64'd2);
      end
      outReady = 1'b1;
      @(negedge clk);
      checkVal("hold released", {63'd0, outValid}, 64'd0);

      applyStimulus(4'd11, 8'h21, 8'h13);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checkVal("abort out_valid", {63'd0, outValid}, 64'd0);
      checkVal("abort in_ready", {63'd0, inReady}, 64'd1);
      rst  = 1'b0;
      seen = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (outValid === 1'b1) seen++;
      end
      checkVal("abort no result", 64'(seen), 64'd0);

      applyStimulus(4'd15, 8'h12, 8'h34);
      checkOutput(4'd15, 8'h12, 8'h34, expRes);
      checkVal("RSVD err", {63'd0, errOut}, 64'd1);
      checkVal("RSVD result", {56'd0, resultOut}, 64'd0);

      for (int i = 0; i < 60; i++) begin
         rf = 4'($urandom_range(0, 15));
         ra = 8'($urandom);
         rb = 8'($urandom);
         case ($urandom_range(0, 7))
            0: rb = 8'h00;
            1: rb = ra;
            2: begin ra = 8'h80; rb = 8'hFF; end
            default: ;
         endcase
         applyStimulus(rf, ra, rb);
         checkOutput(rf, ra, rb, expRes);
      end
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
